// File: rtl/wb_master_seq.sv
// wb_master_seq: Wishbone classic initiator running 1..16-beat incrementing word bursts.
// Latency: a zero-wait read beat raises stb 1 cycle after accept and rsp_valid 1 cycle after ack.
// Backpressure: cmd_ready only in IDLE; write beats wait on wdat_valid; read beats hold in RESP until rsp_ready.
// Ports: clk/rst (async, active high); cmd_* command channel; wdat_* write-data channel;
//        rsp_* read-response channel; done/err/busy status; wbm_* Wishbone initiator port.
module wb_master_seq #(
  parameter int TIMEOUT = 255,
  parameter int TSIZE   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [3:0]  cmd_sel,
  input  logic [3:0]  cmd_len,
  input  logic        wdat_valid,
  output logic        wdat_ready,
  input  logic [31:0] wdat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [2:0] {S_IDLE, S_WDAT, S_BUS, S_RESP, S_NEXT} state_t;

  // Last tcnt value at which stb may still be waiting; the beat aborts on that cycle.
  localparam logic [TSIZE-1:0] TLAST = TSIZE'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic [TSIZE-1:0]  r_tcnt, w_tcnt_nxt;
  logic [3:0]        r_bcnt, w_bcnt_nxt;
  logic              r_cmd_ready, r_wdat_ready, r_rsp_valid, r_done, r_err, r_busy;
  logic              r_cyc, r_stb, r_we;
  logic [31:0]       r_rsp_dat, r_adr, r_dat_o;
  logic [3:0]        r_sel;
  logic              w_cmd_ready_nxt, w_wdat_ready_nxt, w_rsp_valid_nxt, w_done_nxt, w_err_nxt;
  logic              w_busy_nxt, w_stb_nxt, w_we_nxt;
  logic [31:0]       w_rsp_dat_nxt, w_adr_nxt, w_dat_o_nxt;
  logic [3:0]        w_sel_nxt;

  logic w_cmd_acc, w_wdat_acc, w_ack, w_tout, w_rsp_acc, w_last;

  assign w_cmd_acc  = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
  assign w_wdat_acc = (r_state == S_WDAT) && wdat_valid && r_wdat_ready;
  assign w_ack      = (r_state == S_BUS) && wbm_ack_i;
  // Ack wins over timeout when both land on the same edge.
  assign w_tout     = (r_state == S_BUS) && !wbm_ack_i && (r_tcnt == TLAST);
  assign w_rsp_acc  = (r_state == S_RESP) && r_rsp_valid && rsp_ready;
  assign w_last     = (r_bcnt == 4'd0);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tcnt       <= '0;
      r_bcnt       <= 4'd0;
      r_cmd_ready  <= 1'b0;
      r_wdat_ready <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= 32'd0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= 32'd0;
      r_dat_o      <= 32'd0;
      r_sel        <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_bcnt       <= w_bcnt_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_wdat_ready <= w_wdat_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_dat    <= w_rsp_dat_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= w_busy_nxt;
      r_cyc        <= w_busy_nxt;
      r_stb        <= w_stb_nxt;
      r_we         <= w_we_nxt;
      r_adr        <= w_adr_nxt;
      r_dat_o      <= w_dat_o_nxt;
      r_sel        <= w_sel_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_acc) w_state_nxt = cmd_we ? S_WDAT : S_BUS;
      S_WDAT: if (w_wdat_acc) w_state_nxt = S_BUS;
      S_BUS: begin
        if (w_ack)       w_state_nxt = r_we ? S_NEXT : S_RESP;
        else if (w_tout) w_state_nxt = S_IDLE;
      end
      S_RESP: if (w_rsp_acc) w_state_nxt = S_NEXT;
      S_NEXT: begin
        if (w_last) w_state_nxt = S_IDLE;
        else        w_state_nxt = r_we ? S_WDAT : S_BUS;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    w_bcnt_nxt    = r_bcnt;
    w_we_nxt      = r_we;
    w_adr_nxt     = r_adr;
    w_sel_nxt     = r_sel;
    w_dat_o_nxt   = r_dat_o;
    w_rsp_dat_nxt = r_rsp_dat;
    // Counting only while in BUS makes every entry to BUS start from zero.
    w_tcnt_nxt    = (r_state == S_BUS) ? r_tcnt + 1'b1 : '0;

    if (w_cmd_acc) begin
      w_we_nxt   = cmd_we;
      w_adr_nxt  = cmd_adr & 32'hFFFF_FFFC;
      w_sel_nxt  = cmd_sel;
      w_bcnt_nxt = cmd_len;
    end
    if (w_wdat_acc) w_dat_o_nxt = wdat;
    if (w_ack && !r_we) w_rsp_dat_nxt = wbm_dat_i;
    if ((r_state == S_NEXT) && !w_last) begin
      w_bcnt_nxt = r_bcnt - 4'd1;
      w_adr_nxt  = r_adr + 32'd4;
    end

    // cmd_ready rises only after a full cycle in IDLE, so the earliest
    // re-accept is the cycle after done (and one cycle after reset release).
    w_cmd_ready_nxt  = (r_state == S_IDLE) && (w_state_nxt == S_IDLE);
    w_wdat_ready_nxt = (w_state_nxt == S_WDAT);
    w_stb_nxt        = (w_state_nxt == S_BUS);
    w_rsp_valid_nxt  = (w_state_nxt == S_RESP);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_done_nxt       = ((r_state == S_NEXT) && w_last) || w_tout;
    w_err_nxt        = w_tout;
  end

  assign cmd_ready  = r_cmd_ready;
  assign wdat_ready = r_wdat_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_dat    = r_rsp_dat;
  assign done       = r_done;
  assign err        = r_err;
  assign busy       = r_busy;
  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_stb;
  assign wbm_we_o   = r_we;
  assign wbm_adr_o  = r_adr;
  assign wbm_dat_o  = r_dat_o;
  assign wbm_sel_o  = r_sel;

endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
- Wishbone classic initiator that turns single- or multi-beat commands into 32-bit bus cycles on an internal Wishbone segment.
- Beats run at incrementing word addresses.
- Used to drive our register/memory responders (gonso-style slaves) from on-chip sequencers and bench-side loaders, without the management SoC.
- One transaction in flight. Valid/ready command, write-data and read-response channels. Per-beat ack timeout with error reporting.

Parameters:
- TIMEOUT, 255, cycles to wait for wbm_ack_i per beat before aborting (1..2^TSIZE-1).
- TSIZE, 8, width of the timeout counter in bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1: write burst, 0: read burst
- cmd_adr  in  32  byte address of first beat; bits [1:0] ignored and forced to 0
- cmd_sel  in  4  byte enables, applied to every beat
- cmd_len  in  4  beats minus one (0 to 15, i.e. 1 to 16 beats)
- wdat_valid  in  1  write word offered
- wdat_ready  out  1  write word consumed
- wdat  in  32  write word
- rsp_valid  out  1  read word available
- rsp_ready  in  1  read word taken
- rsp_dat  out  32  read word
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle pulse with done when a burst aborted on timeout
- busy  out  1  high from command accept until done
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_sel_o  out  4  Wishbone byte select
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge

Behaviour:
- All outputs are registered. On rst every output is 0 and the state is IDLE; this holds equally when rst asserts mid-burst. An aborted burst produces no done and no err.
- States and transitions:
  - IDLE: cmd_ready=1. On accept, latch we, adr (with [1:0]=0), sel and len into beat counter bcnt. Set busy=1 and wbm_cyc_o=1. Go to WDAT if write, else BUS.
  - WDAT: wdat_ready=1. On wdat_valid, latch wdat into wbm_dat_o, drop wdat_ready and go to BUS on the next cycle. wbm_stb_o stays 0 in this state.
  - BUS: wbm_stb_o=1 and the timeout counter tcnt increments each cycle.
    - wbm_ack_i is sampled only in BUS. On ack, wbm_stb_o drops at that same edge, so the responder sees at most one valid cycle per ack.
    - On ack for a read: capture wbm_dat_i into rsp_dat, set rsp_valid=1, go to RESP.
    - On ack for a write: go to NEXT.
    - If tcnt reaches TIMEOUT without ack: drop cyc and stb, pulse done and err, clear busy, go to IDLE. Remaining beats are discarded and no further wdat is consumed.
  - RESP: hold rsp_valid and rsp_dat until rsp_ready; then clear rsp_valid and go to NEXT. If rsp_ready is already high when rsp_valid rises, the handshake completes on that cycle.
  - NEXT: if bcnt==0, drop wbm_cyc_o, pulse done (err=0), clear busy and go to IDLE. Otherwise decrement bcnt, add 4 to wbm_adr_o (wraps modulo 2^32) and go to WDAT or BUS.
- wbm_cyc_o stays high for the whole burst, including WDAT, RESP and NEXT.
- wbm_we_o and wbm_sel_o are constant over the burst.
- tcnt clears on every entry to BUS. An ack arriving on the same edge tcnt reaches TIMEOUT counts as success (ack wins).
- Minimum latency for a read beat with a zero-wait responder: stb rises 1 cycle after accept, ack arrives 1 cycle later, rsp_valid 1 cycle after that.
- A new command is accepted only in IDLE; no back-to-back overlap. The earliest next accept is the cycle after done.
- A stray ack outside BUS is ignored.

Test Plan:
- Single read: cmd adr=0x3000_0004, len=0, responder returns 0xDEADBEEF after 1 wait cycle -> one stb pulse at adr 0x3000_0004, we=0; rsp_dat=0xDEADBEEF; done=1, err=0, cyc low afterwards.
- Write burst: adr=0x3000_1000, len=3, sel=0xF, wdat 0x11,0x22,0x33,0x44 with wdat_valid gapped by 2 cycles -> four stb cycles at 0x..1000/1004/1008/100C with matching data; cyc held high throughout; exactly one done.
- Read backpressure: len=1, rsp_ready held low 5 cycles -> rsp_valid/rsp_dat stable, second stb not issued until first response taken.
- Timeout: TIMEOUT=8, responder never acks, len=2 -> stb high exactly 8 cycles, then cyc/stb low; done=err=1 for one cycle; no second beat issued.
- Wrap and alignment: adr=0xFFFF_FFFE, len=1 -> beats at 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-burst: assert rst during BUS of beat 2 of 4 -> all outputs 0 immediately (asynchronous), no done; next command after release runs normally.
